soc_bus_arbiter: RTL

SOC_BUS_ARBITER -- requirements
Module: soc_bus_arbiter

---
 rtl/soc_bus_arbiter_if.sv | 64 ++++++
 rtl/soc_bus_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/soc_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// soc_bus_arbiter_if
// Bundles the two master request/response channels and the memory-bus channel
// of soc_bus_arbiter. Member names carry their direction as seen from the
// arbiter (_i = into the arbiter, _o = out of the arbiter).
//   modport slave  : the arbiter's view (serves the masters, drives the bus)
//   modport master : the environment's view (masters plus memory bus)
// Parameters:
//   ADDR_WIDTH : address width
//   DATA_WIDTH : data width; byte-select width is DATA_WIDTH/8
// -----------------------------------------------------------------------------
interface soc_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   // master 0 (CPU)
   logic                  m0_stb_i;
   logic                  m0_we_i;
   logic [SEL_WIDTH-1:0]  m0_sel_i;
   logic [ADDR_WIDTH-1:0] m0_addr_i;
   logic [DATA_WIDTH-1:0] m0_data_i;
   logic [DATA_WIDTH-1:0] m0_data_o;
   logic                  m0_ack_o;
   logic                  m0_err_o;

   // master 1 (external host port)
   logic                  m1_stb_i;
   logic                  m1_we_i;
   logic [SEL_WIDTH-1:0]  m1_sel_i;
   logic [ADDR_WIDTH-1:0] m1_addr_i;
   logic [DATA_WIDTH-1:0] m1_data_i;
   logic [DATA_WIDTH-1:0] m1_data_o;
   logic                  m1_ack_o;
   logic                  m1_err_o;

   // memory bus
   logic                  s_stb_o;
   logic                  s_we_o;
   logic [SEL_WIDTH-1:0]  s_sel_o;
   logic [ADDR_WIDTH-1:0] s_addr_o;
   logic [DATA_WIDTH-1:0] s_data_o;
   logic [DATA_WIDTH-1:0] s_data_i;
   logic                  s_ack_i;

   modport slave (
      input  m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i,
      output m0_data_o, m0_ack_o, m0_err_o,
      input  m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i,
      output m1_data_o, m1_ack_o, m1_err_o,
      output s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
      input  s_data_i, s_ack_i
   );

   modport master (
      output m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i,
      input  m0_data_o, m0_ack_o, m0_err_o,
      output m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i,
      input  m1_data_o, m1_ack_o, m1_err_o,
      input  s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
      output s_data_i, s_ack_i
   );
endinterface

// File: rtl/soc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// soc_bus_arbiter
// Two-master, single-outstanding-transfer arbiter onto one memory bus.
// Round-robin between master 0 (CPU) and master 1 (host port), with an
// optional lock that restricts eligibility to one master, and a per-transfer
// timeout that returns a one-cycle error pulse to the owner.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   bus        : soc_bus_arbiter_if.slave (master channels + memory bus)
//   lock_i     : when 1 only master lock_sel_i may be granted
//   lock_sel_i : master index honoured while locked
//   owner_o    : current or last granted master
//   busy_o     : 1 while a transfer is in progress
// -----------------------------------------------------------------------------
module soc_bus_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   soc_bus_arbiter_if.slave        bus,
   input  logic                    lock_i,
   input  logic                    lock_sel_i,
   output logic                    owner_o,
   output logic                    busy_o
);
   localparam int          SEL_WIDTH = DATA_WIDTH / 8;
   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t      state_q;
   logic        owner_q;
   logic        last_owner_q;
   logic [15:0] cnt_q;

   logic                  elig0_s;
   logic                  elig1_s;
   logic                  grant_vld_s;
   logic                  grant_idx_s;
   logic                  own_stb_s;
   logic                  own_we_s;
   logic [SEL_WIDTH-1:0]  own_sel_s;
   logic [ADDR_WIDTH-1:0] own_addr_s;
   logic [DATA_WIDTH-1:0] own_wdata_s;
   logic                  busy_s;
   logic                  timeout_s;
   logic                  live_s;
   logic                  ack_fwd_s;
   logic                  err_s;

   // Arbitration: eligibility under lock, round robin on a tie.
   always_comb begin
      elig0_s     = bus.m0_stb_i & (~lock_i | (lock_sel_i == 1'b0));
      elig1_s     = bus.m1_stb_i & (~lock_i | (lock_sel_i == 1'b1));
      grant_vld_s = elig0_s | elig1_s;
      if (elig0_s & elig1_s) begin
         grant_idx_s = ~last_owner_q;
      end else begin
         grant_idx_s = elig1_s;
      end
   end

   // Request mux: select the owner's request fields.
   always_comb begin
      if (owner_q) begin
         own_stb_s   = bus.m1_stb_i;
         own_we_s    = bus.m1_we_i;
         own_sel_s   = bus.m1_sel_i;
         own_addr_s  = bus.m1_addr_i;
         own_wdata_s = bus.m1_data_i;
      end else begin
         own_stb_s   = bus.m0_stb_i;
         own_we_s    = bus.m0_we_i;
         own_sel_s   = bus.m0_sel_i;
         own_addr_s  = bus.m0_addr_i;
         own_wdata_s = bus.m0_data_i;
      end
   end

   // Transfer status: a transfer is live only while the owner keeps its
   // strobe up, so an abort suppresses both ack and err. Ack beats timeout.
   always_comb begin
      busy_s    = (state_q == ST_BUSY);
      timeout_s = (cnt_q == TMO_LIMIT);
      live_s    = busy_s & own_stb_s;
      ack_fwd_s = live_s & bus.s_ack_i;
      err_s     = live_s & timeout_s & ~bus.s_ack_i;
   end

   // Bus and master outputs; the strobe is withdrawn in the error cycle.
   always_comb begin
      bus.s_stb_o   = live_s & ~err_s;
      bus.s_we_o    = own_we_s;
      bus.s_sel_o   = own_sel_s;
      bus.s_addr_o  = own_addr_s;
      bus.s_data_o  = own_wdata_s;
      bus.m0_data_o = bus.s_data_i;
      bus.m1_data_o = bus.s_data_i;
      bus.m0_ack_o  = ack_fwd_s & ~owner_q;
      bus.m1_ack_o  = ack_fwd_s &  owner_q;
      bus.m0_err_o  = err_s & ~owner_q;
      bus.m1_err_o  = err_s &  owner_q;
   end

   // Control FSM: grant in IDLE, one transfer per BUSY visit. Leaving BUSY
   // always passes through IDLE, which gives the mandatory idle cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         cnt_q        <= 16'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_vld_s) begin
                  state_q      <= ST_BUSY;
                  owner_q      <= grant_idx_s;
                  last_owner_q <= grant_idx_s;
                  cnt_q        <= 16'd0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (~own_stb_s | bus.s_ack_i | timeout_s) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_BUSY;
                  if (cnt_q != TMO_LIMIT) begin
                     cnt_q <= cnt_q + 16'd1;
                  end else begin
                     cnt_q <= cnt_q;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o  = (state_q == ST_BUSY);
   assign owner_o = owner_q;

endmodule
